// File: rtl/core_alu_pipe.sv
// Pipelined Wishbone ALU: add/sub/mul/mac with a fixed LAT-cycle pipeline.
// Results are queued in a credit-protected FIFO that is read through the bus.
module core_alu_pipe #(
  parameter int          WIDTH     = 8,
  parameter int          LAT       = 8,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_data,
  input  logic [31:0] i_wb_addr,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = DEPTH[CW-1:0];
  localparam logic [5:0]      DEPTH6   = DEPTH[5:0];
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);

  logic [WIDTH-1:0] opa_r, opb_r, opm_r;
  logic             uflow_r;
  logic [LAT-1:0]   valid_r;
  logic [1:0]       op_r [LAT];
  logic [WIDTH-1:0] pa_r [LAT];
  logic [WIDTH-1:0] pb_r [LAT];
  logic [WIDTH-1:0] pm_r [LAT];
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [CW-1:0]    count_r;

  logic [31:0]      offset_s, status_s, rdata_s;
  logic             in_win_s, sel_opa_s, sel_opb_s, sel_opm_s, sel_cmd_s, sel_res_s, sel_sts_s;
  logic             req_s, acc_s, wr_acc_s, rd_acc_s;
  logic             launch_s, push_s, pop_s, uflow_set_s, uflow_clr_s;
  logic [5:0]       inflight_s, count6_s;
  logic [WIDTH-1:0] exit_res_s;
  logic             unused_s;

  assign offset_s  = i_wb_addr - BASE_ADDR;
  assign in_win_s  = (offset_s < 32'd24);
  assign sel_opa_s = in_win_s && (offset_s == 32'h0000_0000);
  assign sel_opb_s = in_win_s && (offset_s == 32'h0000_0004);
  assign sel_opm_s = in_win_s && (offset_s == 32'h0000_0008);
  assign sel_cmd_s = in_win_s && (offset_s == 32'h0000_000C);
  assign sel_res_s = in_win_s && (offset_s == 32'h0000_0010);
  assign sel_sts_s = in_win_s && (offset_s == 32'h0000_0014);

  assign req_s    = i_wb_cyc & i_wb_stb;
  assign count6_s = {{(6-CW){1'b0}}, count_r};

  // Credits: a CMD may launch only if every in-flight op still has a FIFO slot.
  assign o_wb_stall = reset & req_s & i_wb_we & sel_cmd_s & ((inflight_s + count6_s) >= DEPTH6);

  assign acc_s       = req_s & ~o_wb_stall;
  assign wr_acc_s    = acc_s & i_wb_we;
  assign rd_acc_s    = acc_s & ~i_wb_we;
  assign launch_s    = wr_acc_s & sel_cmd_s;
  assign push_s      = valid_r[LAT-1];
  assign pop_s       = rd_acc_s & sel_res_s & (count_r != {CW{1'b0}});
  assign uflow_set_s = rd_acc_s & sel_res_s & (count_r == {CW{1'b0}});
  assign uflow_clr_s = wr_acc_s & sel_sts_s & i_wb_data[2];
  assign unused_s    = ^i_wb_data[31:WIDTH];

  // Number of occupied pipeline stages.
  always_comb begin
    inflight_s = 6'd0;
    for (int i = 0; i < LAT; i++) begin
      inflight_s = inflight_s + {5'd0, valid_r[i]};
    end
  end

  // Arithmetic on the operands leaving the last pipeline stage.
  always_comb begin
    case (op_r[LAT-1])
      2'b00:   exit_res_s = pa_r[LAT-1] + pb_r[LAT-1];
      2'b01:   exit_res_s = pa_r[LAT-1] * pb_r[LAT-1];
      2'b10:   exit_res_s = pm_r[LAT-1] * pa_r[LAT-1] + pb_r[LAT-1];
      2'b11:   exit_res_s = pa_r[LAT-1] - pb_r[LAT-1];
      default: exit_res_s = {WIDTH{1'b0}};
    endcase
  end

  // STATUS word assembled from the current FIFO and pipeline state.
  always_comb begin
    status_s         = 32'd0;
    status_s[0]      = (count_r == {CW{1'b0}});
    status_s[1]      = (count_r == FULL_CNT);
    status_s[2]      = uflow_r;
    status_s[3]      = |valid_r;
    status_s[8 +: CW] = count_r;
  end

  // Read-data mux; an empty RESULT read and unmapped offsets return zero.
  always_comb begin
    rdata_s = 32'd0;
    if (sel_opa_s) begin
      rdata_s[WIDTH-1:0] = opa_r;
    end else if (sel_opb_s) begin
      rdata_s[WIDTH-1:0] = opb_r;
    end else if (sel_opm_s) begin
      rdata_s[WIDTH-1:0] = opm_r;
    end else if (sel_res_s && (count_r != {CW{1'b0}})) begin
      rdata_s[WIDTH-1:0] = mem_r[rptr_r];
    end else if (sel_sts_s) begin
      rdata_s = status_s;
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Bus-side registers: operands, sticky underflow, ack and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_r     <= {WIDTH{1'b0}};
      opb_r     <= {WIDTH{1'b0}};
      opm_r     <= {WIDTH{1'b0}};
      uflow_r   <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'd0;
    end else begin
      o_wb_ack <= acc_s & in_win_s;
      if (rd_acc_s && in_win_s) o_wb_data <= rdata_s;
      if (wr_acc_s && sel_opa_s) opa_r <= i_wb_data[WIDTH-1:0];
      if (wr_acc_s && sel_opb_s) opb_r <= i_wb_data[WIDTH-1:0];
      if (wr_acc_s && sel_opm_s) opm_r <= i_wb_data[WIDTH-1:0];
      if (uflow_set_s) begin
        uflow_r <= 1'b1;
      end else if (uflow_clr_s) begin
        uflow_r <= 1'b0;
      end
    end
  end

  // Operation pipeline: valid, op and operand snapshot shift one stage per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        op_r[i] <= 2'b00;
        pa_r[i] <= {WIDTH{1'b0}};
        pb_r[i] <= {WIDTH{1'b0}};
        pm_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_r <= {valid_r[LAT-2:0], launch_s};
      op_r[0] <= i_wb_data[1:0];
      pa_r[0] <= opa_r;
      pb_r[0] <= opb_r;
      pm_r[0] <= opm_r;
      for (int i = 1; i < LAT; i++) begin
        op_r[i] <= op_r[i-1];
        pa_r[i] <= pa_r[i-1];
        pb_r[i] <= pb_r[i-1];
        pm_r[i] <= pm_r[i-1];
      end
    end
  end

  // Result FIFO; credits guarantee a push never meets a full queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= exit_res_s;
        wptr_r        <= wptr_r + PTR_ONE;
      end
      if (pop_s) rptr_r <= rptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_core_alu_pipe.sv
// Directed self-checking bench for core_alu_pipe (WIDTH=8, LAT=8, DEPTH=4).
module tb_core_alu_pipe;
  localparam int          LAT  = 8;
  localparam logic [31:0] BASE = 32'h3000_0100;
  localparam logic [31:0] OPA  = BASE + 32'h00;
  localparam logic [31:0] OPB  = BASE + 32'h04;
  localparam logic [31:0] OPM  = BASE + 32'h08;
  localparam logic [31:0] CMD  = BASE + 32'h0C;
  localparam logic [31:0] RES  = BASE + 32'h10;
  localparam logic [31:0] STS  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_wdata = 32'd0, wb_addr = 32'd0;
  logic        wb_ack, wb_stall;
  logic [31:0] wb_rdata;
  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;

  core_alu_pipe #(.WIDTH(8), .LAT(LAT), .DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_data(wb_wdata), .i_wb_addr(wb_addr),
    .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 32'd0; wb_wdata = 32'd0;
  endtask

  // One request; returns #1 after its accept edge with ack/data sampled there.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_ack, output logic [31:0] rdata,
                      output int acc_edge, output int nst);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
    nst = 0;
    #1;
    while (wb_stall && nst < 100) begin
      @(posedge clk); #1;
      nst++;
    end
    @(posedge clk); #1;
    acc_edge = edge_cnt;
    rdata = wb_rdata;
    chk("ack", {31'd0, wb_ack}, {31'd0, exp_ack});
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d; int e, s;
    xfer(1'b1, addr, data, 1'b1, d, e, s);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; int e, s;
    xfer(1'b0, addr, 32'd0, 1'b1, d, e, s);
    chk(tag, d, exp);
  endtask

  // Reads report the state before their accept edge, so the count changed one edge earlier.
  task automatic poll_flip(output int flip);
    logic [31:0] d; int e, s;
    flip = -1;
    for (int i = 0; i < 40 && flip < 0; i++) begin
      xfer(1'b0, STS, 32'd0, 1'b1, d, e, s);
      if (d[12:8] != 5'd0) flip = e - 1;
    end
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp);
    int f;
    poll_flip(f);
    rd_chk(tag, RES, exp);
  endtask

  initial begin
    logic [31:0] d;
    int n, n5, f, s;

    // Reset state, including stall held low with a CMD request present.
    repeat (2) @(posedge clk);
    #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = CMD;
    #1;
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_data", wb_rdata, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    rd_chk("rst_status", STS, 32'h0000_0001);

    // add with wrap and exact latency of the first push
    wr(OPA, 32'd200);
    wr(OPB, 32'd100);
    xfer(1'b1, CMD, 32'd0, 1'b1, d, n, s);
    poll_flip(f);
    chk("add_latency", f, n + LAT);
    rd_chk("add_wrap", RES, 32'd44);
    rd_chk("status_idle", STS, 32'h0000_0001);

    // sub, plain and wrapping
    wr(CMD, 32'd3);
    wait_pop("sub", 32'd100);
    wr(OPA, 32'd100);
    wr(OPB, 32'd200);
    wr(CMD, 32'd3);
    wait_pop("sub_wrap", 32'd156);

    // mul / mac queued together, popped in issue order
    wr(OPA, 32'd13); wr(OPB, 32'd11); wr(CMD, 32'd1);
    wr(OPM, 32'd3);  wr(OPA, 32'd5);  wr(OPB, 32'd7);  wr(CMD, 32'd2);
    wr(OPM, 32'd20); wr(OPA, 32'd20); wr(OPB, 32'd0);  wr(CMD, 32'd2);
    wait_pop("mul", 32'd143);
    wait_pop("mac", 32'd22);
    wait_pop("mac_wrap", 32'd144);

    // register readback, width masking, CMD reads zero, out-of-window no ack
    rd_chk("opm_rb", OPM, 32'd20);
    wr(OPA, 32'hFFFF_FF12);
    rd_chk("opa_mask", OPA, 32'h0000_0012);
    rd_chk("cmd_rd", CMD, 32'd0);
    xfer(1'b0, BASE + 32'h18, 32'd0, 1'b0, d, n, s);

    // backpressure: four back-to-back CMDs, fifth stalls until a pop
    wr(OPA, 32'd10); wr(OPB, 32'd1); wr(OPM, 32'd2);
    wr(CMD, 32'd0); wr(CMD, 32'd3); wr(CMD, 32'd1); wr(CMD, 32'd2);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = CMD; wb_wdata = 32'd0;
    #1;
    chk("stall_inflight", {31'd0, wb_stall}, 32'd1);
    repeat (LAT + 2) begin
      @(posedge clk); #1;
    end
    chk("stall_full", {31'd0, wb_stall}, 32'd1);
    chk("stall_noack", {31'd0, wb_ack}, 32'd0);
    bus_idle();
    rd_chk("status_full", STS, 32'h0000_0402);
    rd_chk("bp_pop0", RES, 32'd11);
    xfer(1'b1, CMD, 32'd0, 1'b1, d, n5, s);
    chk("stall_released", s, 32'd0);
    rd_chk("bp_pop1", RES, 32'd9);
    rd_chk("bp_pop2", RES, 32'd10);
    rd_chk("bp_pop3", RES, 32'd21);
    poll_flip(f);
    chk("fifth_latency", f, n5 + LAT);
    rd_chk("bp_pop4", RES, 32'd11);

    // empty read sets sticky underflow; STATUS write bit2 clears it
    rd_chk("empty_rd", RES, 32'd0);
    rd_chk("uflow_set", STS, 32'h0000_0005);
    wr(STS, 32'h0000_0004);
    rd_chk("uflow_clr", STS, 32'h0000_0001);

    // reset mid-flight discards in-flight ops
    wr(CMD, 32'd0); wr(CMD, 32'd1); wr(CMD, 32'd2);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_ack", {31'd0, wb_ack}, 32'd0);
    chk("async_data", wb_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    rd_chk("midrst_status", STS, 32'h0000_0001);
    repeat (LAT + 4) @(posedge clk);
    #1;
    rd_chk("no_late_push", STS, 32'h0000_0001);
    rd_chk("opa_cleared", OPA, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
